// File: rtl/aes_ofb_byte_stream.sv
// aes_ofb_byte_stream
// Byte-stream adapter around the AES-128 OFB core. Incoming bytes are packed
// MSB-first into a 128-bit block and handed to the core with a one-cycle load
// strobe. Once the core reports done, the result is replayed as a byte stream.
// A message that ends early (s_last) produces a zero-padded block, and only
// the bytes that were actually received are sent back out. If the core never
// answers, the block is dropped after TIMEOUT_CYCLES and a sticky error flag is
// raised.

module aes_ofb_byte_stream #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode_in,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [7:0]   m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
    output logic         core_ld,
    output logic         core_mode,
    output logic [127:0] core_data_in,
    input  logic         core_done,
    input  logic [127:0] core_data_out,
    output logic         busy,
    output logic         err_timeout
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [3:0]           byte_cnt_q,  byte_cnt_d;
    logic [127:0]         block_q,     block_d;
    logic [127:0]         core_data_q, core_data_d;
    logic                 mode_q,      mode_d;
    logic [3:0]           last_idx_q,  last_idx_d;
    logic                 last_flag_q, last_flag_d;
    logic [TIMER_W-1:0]   timer_q,     timer_d;
    logic [127:0]         result_q,    result_d;
    logic [3:0]           idx_q,       idx_d;
    logic                 err_q,       err_d;

    // Bit position of the top of the byte slot: byte k sits at [127-8k -: 8],
    // and 127-8k is simply {~k, 3'b111} for a 4-bit k.
    logic [6:0]           fill_hi;
    logic [6:0]           drain_hi;

    assign fill_hi  = {~byte_cnt_q, 3'b111};
    assign drain_hi = {~idx_q, 3'b111};

    // State register and all datapath flops; reset clears everything, which
    // also throws away any partially collected block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            byte_cnt_q  <= 4'd0;
            block_q     <= 128'd0;
            core_data_q <= 128'd0;
            mode_q      <= 1'b0;
            last_idx_q  <= 4'd0;
            last_flag_q <= 1'b0;
            timer_q     <= '0;
            result_q    <= 128'd0;
            idx_q       <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            block_q     <= block_d;
            core_data_q <= core_data_d;
            mode_q      <= mode_d;
            last_idx_q  <= last_idx_d;
            last_flag_q <= last_flag_d;
            timer_q     <= timer_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath update for the FILL/LOAD/WAIT/DRAIN sequence.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        block_d     = block_q;
        core_data_d = core_data_q;
        mode_d      = mode_q;
        last_idx_d  = last_idx_q;
        last_flag_d = last_flag_q;
        timer_d     = timer_q;
        result_d    = result_q;
        idx_d       = idx_q;
        err_d       = err_q;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    // The first byte starts a fresh, zeroed block so that a
                    // short block is padded with zeros automatically.
                    if (byte_cnt_q == 4'd0) begin
                        block_d = {s_data, 120'd0};
                        mode_d  = mode_in;
                    end else begin
                        block_d[fill_hi -: 8] = s_data;
                    end

                    if ((byte_cnt_q == 4'd15) || s_last) begin
                        // The completed block is captured for the core here
                        // so it is already valid during the load strobe.
                        core_data_d = block_d;
                        last_idx_d  = byte_cnt_q;
                        last_flag_d = s_last;
                        byte_cnt_d  = 4'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + 4'd1;
                    end
                end
            end

            ST_LOAD: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (core_done) begin
                    result_d = core_data_out;
                    idx_d    = 4'd0;
                    state_d  = ST_DRAIN;
                end else if (timer_q == TIMER_MAX) begin
                    err_d    = 1'b1;
                    state_d  = ST_FILL;
                end else begin
                    timer_d  = timer_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (m_ready) begin
                    if (idx_q == last_idx_q) begin
                        idx_d   = 4'd0;
                        state_d = ST_FILL;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so m_data and m_last
    // cannot move while the downstream side is stalling.
    always_comb begin
        s_ready      = (state_q == ST_FILL);
        core_ld      = (state_q == ST_LOAD);
        m_valid      = (state_q == ST_DRAIN);
        busy         = (state_q != ST_FILL);
        m_data       = 8'd0;
        m_last       = 1'b0;
        if (state_q == ST_DRAIN) begin
            m_data   = result_q[drain_hi -: 8];
            m_last   = last_flag_q && (idx_q == last_idx_q);
        end
        core_mode    = mode_q;
        core_data_in = core_data_q;
        err_timeout  = err_q;
    end

endmodule
